// File: rtl/weight_wr_bank_router.sv
// Routes a flat weight write stream into four weight banks with bank-local addressing.
// Optional running checksum of accepted words is enabled by defining WEIGHT_CHECKSUM_EN.
module weight_wr_bank_router #(
  parameter int unsigned NUM_WEIGHTS     = 76323,
  parameter int unsigned BANK0_DEPTH     = 432,
  parameter int unsigned BANK1_DEPTH     = 18432,
  parameter int unsigned BANK2_DEPTH     = 36864,
  parameter int unsigned BANK_ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       weight_wr_en,
  input  logic [31:0]                weight_wr_addr,
  input  logic [15:0]                weight_wr_data,
  input  logic                       load_clear,
  output logic [3:0]                 bank_wr_en,
  output logic [BANK_ADDR_WIDTH-1:0] bank_wr_addr,
  output logic [15:0]                bank_wr_data,
  output logic                       weights_loaded,
  output logic                       addr_err,
  output logic [31:0]                weight_checksum
);

  localparam longint BANK3_DEPTH = longint'(NUM_WEIGHTS) - longint'(BANK0_DEPTH)
                                   - longint'(BANK1_DEPTH) - longint'(BANK2_DEPTH);
  localparam longint ADDR_SPAN   = longint'(1) << BANK_ADDR_WIDTH;

  localparam logic [31:0] BASE1     = 32'(BANK0_DEPTH);
  localparam logic [31:0] BASE2     = 32'(BANK0_DEPTH + BANK1_DEPTH);
  localparam logic [31:0] BASE3     = 32'(BANK0_DEPTH + BANK1_DEPTH + BANK2_DEPTH);
  localparam logic [31:0] LIMIT     = 32'(NUM_WEIGHTS);
  // Upstream pads the weight stream up to the next multiple of four past NUM_WEIGHTS.
  localparam logic [31:0] PAD_LIMIT = 32'((NUM_WEIGHTS + 4) / 4 * 4);

  localparam int unsigned    CNT_W   = $clog2(NUM_WEIGHTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_WEIGHTS);

  if (BANK3_DEPTH <= 0 ||
      longint'(BANK0_DEPTH) > ADDR_SPAN || longint'(BANK1_DEPTH) > ADDR_SPAN ||
      longint'(BANK2_DEPTH) > ADDR_SPAN || BANK3_DEPTH > ADDR_SPAN) begin : g_bad_cfg
    $error("weight_wr_bank_router: invalid bank depth configuration");
  end

  logic [3:0]                 hit;
  logic [BANK_ADDR_WIDTH-1:0] local_addr;
  logic                       bad_addr;
  logic                       accept;

  logic [3:0]                 bank_wr_en_q;
  logic [BANK_ADDR_WIDTH-1:0] bank_wr_addr_q, bank_wr_addr_d;
  logic [15:0]                bank_wr_data_q, bank_wr_data_d;
  logic [CNT_W-1:0]           load_cnt_q, load_cnt_d, cnt_base;
  logic                       loaded_q, loaded_d;
  logic                       err_q, err_d;

  always_comb begin
    hit        = 4'b0000;
    local_addr = '0;
    bad_addr   = 1'b0;
    if (weight_wr_en) begin
      if (weight_wr_addr < BASE1) begin
        hit        = 4'b0001;
        local_addr = BANK_ADDR_WIDTH'(weight_wr_addr);
      end else if (weight_wr_addr < BASE2) begin
        hit        = 4'b0010;
        local_addr = BANK_ADDR_WIDTH'(weight_wr_addr - BASE1);
      end else if (weight_wr_addr < BASE3) begin
        hit        = 4'b0100;
        local_addr = BANK_ADDR_WIDTH'(weight_wr_addr - BASE2);
      end else if (weight_wr_addr < LIMIT) begin
        hit        = 4'b1000;
        local_addr = BANK_ADDR_WIDTH'(weight_wr_addr - BASE3);
      end else if (weight_wr_addr >= PAD_LIMIT) begin
        bad_addr = 1'b1;
      end
    end
  end

  assign accept = |hit;

  // Clear takes effect before the same-cycle write is counted.
  always_comb begin
    bank_wr_addr_d = bank_wr_addr_q;
    bank_wr_data_d = bank_wr_data_q;
    if (accept) begin
      bank_wr_addr_d = local_addr;
      bank_wr_data_d = weight_wr_data;
    end
    cnt_base   = load_clear ? '0 : load_cnt_q;
    load_cnt_d = cnt_base;
    if (accept && (cnt_base != CNT_MAX)) begin
      load_cnt_d = cnt_base + CNT_W'(1);
    end
    loaded_d = (load_clear ? 1'b0 : loaded_q) | (load_cnt_d == CNT_MAX);
    err_d    = (load_clear ? 1'b0 : err_q) | bad_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_wr_en_q   <= 4'b0000;
      bank_wr_addr_q <= '0;
      bank_wr_data_q <= '0;
      load_cnt_q     <= '0;
      loaded_q       <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      bank_wr_en_q   <= hit;
      bank_wr_addr_q <= bank_wr_addr_d;
      bank_wr_data_q <= bank_wr_data_d;
      load_cnt_q     <= load_cnt_d;
      loaded_q       <= loaded_d;
      err_q          <= err_d;
    end
  end

`ifdef WEIGHT_CHECKSUM_EN
  logic [31:0] cks_q, cks_d;

  always_comb begin
    cks_d = load_clear ? 32'h0 : cks_q;
    if (accept) begin
      cks_d = cks_d + {16'h0000, weight_wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cks_q <= 32'h0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign weight_checksum = cks_q;
`else
  assign weight_checksum = 32'h0;
`endif

  assign bank_wr_en     = bank_wr_en_q;
  assign bank_wr_addr   = bank_wr_addr_q;
  assign bank_wr_data   = bank_wr_data_q;
  assign weights_loaded = loaded_q;
  assign addr_err       = err_q;

endmodule

// File: tb/tb_weight_wr_bank_router.sv
// Scoreboard bench for weight_wr_bank_router at default parameters.
// Honours WEIGHT_CHECKSUM_EN to pick the expected checksum behaviour.
module tb_weight_wr_bank_router;

  localparam int unsigned N = 76323;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        weight_wr_en = 1'b0;
  logic [31:0] weight_wr_addr = '0;
  logic [15:0] weight_wr_data = '0;
  logic        load_clear = 1'b0;
  logic [3:0]  bank_wr_en;
  logic [15:0] bank_wr_addr;
  logic [15:0] bank_wr_data;
  logic        weights_loaded;
  logic        addr_err;
  logic [31:0] weight_checksum;

  weight_wr_bank_router dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .weight_wr_en    (weight_wr_en),
    .weight_wr_addr  (weight_wr_addr),
    .weight_wr_data  (weight_wr_data),
    .load_clear      (load_clear),
    .bank_wr_en      (bank_wr_en),
    .bank_wr_addr    (bank_wr_addr),
    .bank_wr_data    (bank_wr_data),
    .weights_loaded  (weights_loaded),
    .addr_err        (addr_err),
    .weight_checksum (weight_checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  en;
    logic [15:0] addr;
    logic [15:0] data;
    logic        loaded;
    logic        err;
    logic [31:0] cks;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  // Reference state for the bench model.
  logic [15:0] m_addr = '0;
  logic [15:0] m_data = '0;
  logic        m_loaded = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_cks = '0;
  logic [31:0] m_cnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void route(input logic [31:0] a, output logic [3:0] e,
                                output logic [15:0] la, output logic er);
    e = 4'b0000; la = '0; er = 1'b0;
    if (a < 32'd432) begin e = 4'b0001; la = 16'(a); end
    else if (a < 32'd18864) begin e = 4'b0010; la = 16'(a - 32'd432); end
    else if (a < 32'd55728) begin e = 4'b0100; la = 16'(a - 32'd18864); end
    else if (a < 32'd76323) begin e = 4'b1000; la = 16'(a - 32'd55728); end
    else if (a >= 32'd76324) er = 1'b1;
  endfunction

  task automatic drive(input logic en, input logic [31:0] a, input logic [15:0] d,
                       input logic clr, input logic [3:0] xen, input logic [15:0] xaddr,
                       input logic xerr);
    exp_t e;
    @(negedge clk);
    weight_wr_en   = en;
    weight_wr_addr = a;
    weight_wr_data = d;
    load_clear     = clr;
    if (clr) begin
      m_cnt = 0; m_loaded = 1'b0; m_err = 1'b0; m_cks = 0;
    end
    if (xen != 4'b0000) begin
      m_addr = xaddr;
      m_data = d;
      if (m_cnt < N) m_cnt = m_cnt + 1;
`ifdef WEIGHT_CHECKSUM_EN
      m_cks = m_cks + {16'h0000, d};
`endif
    end
    if (xerr) m_err = 1'b1;
    if (m_cnt == N) m_loaded = 1'b1;
    e = '{en: xen, addr: m_addr, data: m_data, loaded: m_loaded, err: m_err,
          cks: m_cks, cnt: m_cnt};
    sb_q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 16'h0, 1'b0, 4'b0000, 16'h0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: one expected entry per registered output cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("bank_wr_en", 32'(bank_wr_en), 32'(e.en));
        chk("bank_wr_addr", 32'(bank_wr_addr), 32'(e.addr));
        chk("bank_wr_data", 32'(bank_wr_data), 32'(e.data));
        chk("weights_loaded", 32'(weights_loaded), 32'(e.loaded));
        chk("addr_err", 32'(addr_err), 32'(e.err));
        chk("weight_checksum", weight_checksum, e.cks);
        chk("load_cnt", 32'(dut.load_cnt_q), e.cnt);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, 32'(bank_wr_en), 32'h0);
    chk({tag, "_addr"}, 32'(bank_wr_addr), 32'h0);
    chk({tag, "_data"}, 32'(bank_wr_data), 32'h0);
    chk({tag, "_loaded"}, 32'(weights_loaded), 32'h0);
    chk({tag, "_err"}, 32'(addr_err), 32'h0);
    chk({tag, "_cks"}, weight_checksum, 32'h0);
    chk({tag, "_cnt"}, 32'(dut.load_cnt_q), 32'h0);
  endtask

  initial begin
    logic [3:0]  xe;
    logic [15:0] xa;
    logic        xr;

    #23;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic routing and bank boundaries.
    drive(1'b1, 32'd0,     16'h1234, 1'b0, 4'b0001, 16'd0,     1'b0);
    idle();
    drive(1'b1, 32'd432,   16'hA001, 1'b0, 4'b0010, 16'd0,     1'b0);
    drive(1'b1, 32'd55728, 16'hA002, 1'b0, 4'b1000, 16'd0,     1'b0);
    drive(1'b1, 32'd18863, 16'hA003, 1'b0, 4'b0010, 16'd18431, 1'b0);
    drive(1'b1, 32'd18864, 16'hA004, 1'b0, 4'b0100, 16'd0,     1'b0);
    drive(1'b1, 32'd55727, 16'hA005, 1'b0, 4'b0100, 16'd36863, 1'b0);
    drive(1'b1, 32'd76322, 16'hA006, 1'b0, 4'b1000, 16'd20594, 1'b0);
    // Padding slot, then out-of-range addresses.
    drive(1'b1, 32'd76323, 16'hB000, 1'b0, 4'b0000, 16'd0,     1'b0);
    drive(1'b1, 32'd76324, 16'hB001, 1'b0, 4'b0000, 16'd0,     1'b1);
    idle();
    drive(1'b1, 32'hFFFF_FFFF, 16'hB002, 1'b0, 4'b0000, 16'd0, 1'b1);
    drive(1'b0, 32'd0, 16'h0, 1'b1, 4'b0000, 16'd0, 1'b0);
    idle();
    drain();
    chk("err_after_clear", 32'(addr_err), 32'h0);

    // Checksum wrap across 16 bits; clear with a same-cycle write.
    drive(1'b1, 32'd0, 16'hFFFF, 1'b0, 4'b0001, 16'd0, 1'b0);
    drive(1'b1, 32'd1, 16'h0001, 1'b0, 4'b0001, 16'd1, 1'b0);
    idle();
    drain();
`ifdef WEIGHT_CHECKSUM_EN
    chk("cks_sum", weight_checksum, 32'h0001_0000);
`else
    chk("cks_off", weight_checksum, 32'h0);
`endif
    drive(1'b1, 32'd2, 16'h0005, 1'b1, 4'b0001, 16'd2, 1'b0);
    idle();
    drain();
`ifdef WEIGHT_CHECKSUM_EN
    chk("cks_clear_write", weight_checksum, 32'h0000_0005);
`else
    chk("cks_clear_off", weight_checksum, 32'h0);
`endif
    chk("cnt_clear_write", 32'(dut.load_cnt_q), 32'd1);

    // Full sequential load followed by the padding slot.
    drive(1'b0, 32'd0, 16'h0, 1'b1, 4'b0000, 16'd0, 1'b0);
    for (int a = 0; a < int'(N); a++) begin
      route(32'(a), xe, xa, xr);
      drive(1'b1, 32'(a), 16'(a) ^ 16'h5A5A, 1'b0, xe, xa, xr);
    end
    drive(1'b1, 32'd76323, 16'h7777, 1'b0, 4'b0000, 16'd0, 1'b0);
    idle();
    drain();
    chk("loaded_after_full", 32'(weights_loaded), 32'h1);
    chk("no_err_on_pad", 32'(addr_err), 32'h0);
    // Re-write is forwarded; counter stays saturated.
    drive(1'b1, 32'd5, 16'hC0DE, 1'b0, 4'b0001, 16'd5, 1'b0);
    idle();
    drain();
    chk("cnt_saturated", 32'(dut.load_cnt_q), N);

    // Reset in the middle of a load.
    drive(1'b0, 32'd0, 16'h0, 1'b1, 4'b0000, 16'd0, 1'b0);
    for (int a = 0; a < 100; a++) begin
      drive(1'b1, 32'(a), 16'(a + 1), 1'b0, 4'b0001, 16'(a), 1'b0);
    end
    drain();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midload_reset");
    m_addr = '0; m_data = '0; m_loaded = 1'b0; m_err = 1'b0; m_cks = '0; m_cnt = '0;
    @(negedge clk);
    weight_wr_en = 1'b0;
    load_clear   = 1'b0;
    rst_n        = 1'b1;
    drive(1'b1, 32'd500, 16'h0BAD, 1'b0, 4'b0010, 16'd68, 1'b0);
    idle();
    drain();
    chk("cnt_after_reset", 32'(dut.load_cnt_q), 32'd1);
    chk("addr_after_reset", 32'(bank_wr_addr), 32'd68);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
